// File: rtl/spi_ram_pkg.sv
// Shared command encoding and command-word field helpers for the SPI-attached RAM.
package spi_ram_pkg;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } cmd_e;

  localparam int OPC_W = 2;

  // The opcode sits directly above the payload in the command word.
  function automatic int opc_lsb(input int data_width);
    return data_width;
  endfunction

  function automatic int opc_msb(input int data_width);
    return data_width + OPC_W - 1;
  endfunction

endpackage

// File: rtl/spi_ram_core.sv
// Single-port synchronous RAM; the read register only loads on an enabled read.
module spi_ram_core #(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 256,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] rdata_reg;

  // Array contents are deliberately left out of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_reg <= '0;
    end else if (re) begin
      rdata_reg <= mem[addr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/spi_ram_burst.sv
// Command decoder for the SPI-attached RAM: address pointers, range checks,
// optional burst auto-increment and a protocol-error pulse.
module spi_ram_burst
  import spi_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 256,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter bit AUTO_INC   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH+1:0] din,
  input  logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  tx_valid,
  output logic                  err
);

  localparam int OPC_LSB = opc_lsb(DATA_WIDTH);
  localparam int OPC_MSB = opc_msb(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [DATA_WIDTH:0]   DEPTH_EXT = (DATA_WIDTH + 1)'(MEM_DEPTH);

  cmd_e                  cmd;
  logic [DATA_WIDTH-1:0] payload;
  logic                  addr_in_range;

  logic [ADDR_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_WIDTH-1:0] rd_ptr_reg, rd_ptr_next;
  logic                  wa_ok_reg, wa_ok_next;
  logic                  ra_ok_reg, ra_ok_next;
  logic                  tx_valid_reg, tx_valid_next;
  logic                  err_reg, err_next;

  logic                  mem_we;
  logic                  mem_re;
  logic [ADDR_WIDTH-1:0] mem_addr;

  assign cmd     = cmd_e'(din[OPC_MSB:OPC_LSB]);
  assign payload = din[DATA_WIDTH-1:0];

  // Both checks matter: depth may be below 2**ADDR_WIDTH, and the payload may be wider.
  assign addr_in_range = ({1'b0, payload} < DEPTH_EXT) && ((payload >> ADDR_WIDTH) == '0);

  function automatic logic [ADDR_WIDTH-1:0] ptr_incr(input logic [ADDR_WIDTH-1:0] p);
    return (p == LAST_ADDR) ? '0 : p + ADDR_WIDTH'(1);
  endfunction

  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    wa_ok_next    = wa_ok_reg;
    ra_ok_next    = ra_ok_reg;
    tx_valid_next = 1'b0;
    err_next      = 1'b0;
    mem_we        = 1'b0;
    mem_re        = 1'b0;
    if (rx_valid) begin
      unique case (cmd)
        WR_ADDR: begin
          if (addr_in_range) begin
            wr_ptr_next = payload[ADDR_WIDTH-1:0];
            wa_ok_next  = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end
        WR_DATA: begin
          if (wa_ok_reg) begin
            mem_we = 1'b1;
            if (AUTO_INC) wr_ptr_next = ptr_incr(wr_ptr_reg);
          end else begin
            err_next = 1'b1;
          end
        end
        RD_ADDR: begin
          if (addr_in_range) begin
            rd_ptr_next = payload[ADDR_WIDTH-1:0];
            ra_ok_next  = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end
        RD_DATA: begin
          if (ra_ok_reg) begin
            mem_re        = 1'b1;
            tx_valid_next = 1'b1;
            if (AUTO_INC) rd_ptr_next = ptr_incr(rd_ptr_reg);
          end else begin
            err_next = 1'b1;
          end
        end
      endcase
    end
  end

  // One command per cycle, so the single port only ever needs one pointer.
  assign mem_addr = (cmd == RD_DATA) ? rd_ptr_reg : wr_ptr_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      wa_ok_reg    <= 1'b0;
      ra_ok_reg    <= 1'b0;
      tx_valid_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      wa_ok_reg    <= wa_ok_next;
      ra_ok_reg    <= ra_ok_next;
      tx_valid_reg <= tx_valid_next;
      err_reg      <= err_next;
    end
  end

  spi_ram_core #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_core (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (mem_we),
    .re   (mem_re),
    .addr (mem_addr),
    .wdata(payload),
    .rdata(dout)
  );

  assign tx_valid = tx_valid_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_spi_ram_burst.sv
// Bench for spi_ram_burst: three instances (default, depth 200, no auto-increment)
// driven from a vector table plus hand-written reset sequences.
module tb_spi_ram_burst;
  import spi_ram_pkg::*;

  typedef struct {
    int         inst;
    logic [1:0] opc;
    logic [7:0] pay;
    bit         valid;
    bit         exp_tx;
    bit         exp_err;
    logic [7:0] exp_dout;
  } vec_t;

  typedef struct {
    bit         tx;
    bit         err;
    logic [7:0] dout;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n    [3];
  logic [9:0] din      [3];
  logic       rx_valid [3];
  logic [7:0] dout     [3];
  logic       tx_valid [3];
  logic       err      [3];

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  spi_ram_burst u_def (
    .clk(clk), .rst_n(rst_n[0]), .din(din[0]), .rx_valid(rx_valid[0]),
    .dout(dout[0]), .tx_valid(tx_valid[0]), .err(err[0])
  );

  spi_ram_burst #(.MEM_DEPTH(200)) u_d200 (
    .clk(clk), .rst_n(rst_n[1]), .din(din[1]), .rx_valid(rx_valid[1]),
    .dout(dout[1]), .tx_valid(tx_valid[1]), .err(err[1])
  );

  spi_ram_burst #(.AUTO_INC(1'b0)) u_noinc (
    .clk(clk), .rst_n(rst_n[2]), .din(din[2]), .rx_valid(rx_valid[2]),
    .dout(dout[2]), .tx_valid(tx_valid[2]), .err(err[2])
  );

  function automatic vec_t mk(input int inst, input logic [1:0] opc, input logic [7:0] pay,
                              input bit valid, input bit tx, input bit e, input logic [7:0] d);
    vec_t v;
    v.inst = inst; v.opc = opc; v.pay = pay; v.valid = valid;
    v.exp_tx = tx; v.exp_err = e; v.exp_dout = d;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    @(negedge clk);
    din[v.inst]      = {v.opc, v.pay};
    rx_valid[v.inst] = v.valid;
    e.tx = v.exp_tx; e.err = v.exp_err; e.dout = v.exp_dout;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, " tx_valid"}, 8'(tx_valid[v.inst]), 8'(e.tx));
    check({tag, " err"},      8'(err[v.inst]),      8'(e.err));
    check({tag, " dout"},     dout[v.inst],         e.dout);
    $display("%s inst=%0d valid=%0d opc=%0d pay=%h -> tx=%0d err=%0d dout=%h",
             tag, v.inst, v.valid, v.opc, v.pay, tx_valid[v.inst], err[v.inst], dout[v.inst]);
    rx_valid[v.inst] = 1'b0;
  endtask

  task automatic check_reset_outputs(input int i, input string tag);
    check({tag, " dout"},     dout[i],          8'h00);
    check({tag, " tx_valid"}, 8'(tx_valid[i]),  8'h00);
    check({tag, " err"},      8'(err[i]),       8'h00);
    $display("%s inst=%0d -> tx=%0d err=%0d dout=%h", tag, i, tx_valid[i], err[i], dout[i]);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b1; din[i] = '0; rx_valid[i] = 1'b0;
    end
    #2;
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) check_reset_outputs(i, "reset");
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

    // Default instance: protocol errors, basic access, burst with wrap, independence.
    tbl.push_back(mk(0, RD_DATA, 8'h00, 1, 0, 1, 8'h00));
    tbl.push_back(mk(0, WR_ADDR, 8'h10, 1, 0, 0, 8'h00));
    tbl.push_back(mk(0, WR_DATA, 8'hA5, 1, 0, 0, 8'h00));
    tbl.push_back(mk(0, RD_ADDR, 8'h10, 1, 0, 0, 8'h00));
    tbl.push_back(mk(0, RD_DATA, 8'h00, 1, 1, 0, 8'hA5));
    tbl.push_back(mk(0, RD_DATA, 8'h00, 0, 0, 0, 8'hA5));
    tbl.push_back(mk(0, WR_ADDR, 8'hFE, 1, 0, 0, 8'hA5));
    tbl.push_back(mk(0, WR_DATA, 8'h11, 1, 0, 0, 8'hA5));
    tbl.push_back(mk(0, WR_DATA, 8'h22, 1, 0, 0, 8'hA5));
    tbl.push_back(mk(0, WR_DATA, 8'h33, 1, 0, 0, 8'hA5));
    tbl.push_back(mk(0, RD_ADDR, 8'hFE, 1, 0, 0, 8'hA5));
    tbl.push_back(mk(0, RD_DATA, 8'h00, 1, 1, 0, 8'h11));
    tbl.push_back(mk(0, RD_DATA, 8'h00, 1, 1, 0, 8'h22));
    tbl.push_back(mk(0, RD_DATA, 8'h00, 1, 1, 0, 8'h33));
    tbl.push_back(mk(0, WR_DATA, 8'h00, 0, 0, 0, 8'h33));
    tbl.push_back(mk(0, WR_DATA, 8'h44, 1, 0, 0, 8'h33));
    tbl.push_back(mk(0, RD_DATA, 8'h00, 1, 1, 0, 8'h44));
    // Depth 200: 0xC8 is out of range, 0xC7 is the last word.
    tbl.push_back(mk(1, WR_ADDR, 8'hC8, 1, 0, 1, 8'h00));
    tbl.push_back(mk(1, WR_DATA, 8'h99, 1, 0, 1, 8'h00));
    tbl.push_back(mk(1, WR_ADDR, 8'hC7, 1, 0, 0, 8'h00));
    tbl.push_back(mk(1, WR_DATA, 8'hAA, 1, 0, 0, 8'h00));
    tbl.push_back(mk(1, WR_DATA, 8'hBB, 1, 0, 0, 8'h00));
    tbl.push_back(mk(1, RD_ADDR, 8'hC8, 1, 0, 1, 8'h00));
    tbl.push_back(mk(1, RD_ADDR, 8'hC7, 1, 0, 0, 8'h00));
    tbl.push_back(mk(1, RD_DATA, 8'h00, 1, 1, 0, 8'hAA));
    tbl.push_back(mk(1, RD_DATA, 8'h00, 1, 1, 0, 8'hBB));
    tbl.push_back(mk(1, RD_ADDR, 8'h00, 1, 0, 0, 8'hBB));
    tbl.push_back(mk(1, RD_DATA, 8'h00, 1, 1, 0, 8'hBB));
    // No auto-increment: pointers hold.
    tbl.push_back(mk(2, WR_ADDR, 8'h05, 1, 0, 0, 8'h00));
    tbl.push_back(mk(2, WR_DATA, 8'h01, 1, 0, 0, 8'h00));
    tbl.push_back(mk(2, WR_DATA, 8'h02, 1, 0, 0, 8'h00));
    tbl.push_back(mk(2, RD_ADDR, 8'h05, 1, 0, 0, 8'h00));
    tbl.push_back(mk(2, RD_DATA, 8'h00, 1, 1, 0, 8'h02));
    tbl.push_back(mk(2, RD_DATA, 8'h00, 1, 1, 0, 8'h02));

    foreach (tbl[k]) apply(tbl[k], $sformatf("vec%0d", k));

    // Reset asserted mid-burst: outputs clear without a clock edge.
    apply(mk(0, RD_ADDR, 8'hFE, 1, 0, 0, 8'h44), "midrst_a");
    apply(mk(0, RD_DATA, 8'h00, 1, 1, 0, 8'h11), "midrst_b");
    #2;
    rst_n[0] = 1'b0;
    #1;
    check_reset_outputs(0, "midrst_async");
    @(negedge clk);
    rst_n[0] = 1'b1;
    apply(mk(0, RD_DATA, 8'h00, 1, 0, 1, 8'h00), "midrst_rd");
    // A rejected write must leave mem[0] (0x33) intact.
    apply(mk(0, WR_DATA, 8'h77, 1, 0, 1, 8'h00), "midrst_wr");
    apply(mk(0, RD_ADDR, 8'h00, 1, 0, 0, 8'h00), "midrst_ra");
    apply(mk(0, RD_DATA, 8'h00, 1, 1, 0, 8'h33), "midrst_chk");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
